// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for a shared mux4_1 path: four requesters, registered
// one-hot grant and mux selects, with a bounded hold time while others wait.
module mux4_rr_sched #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // The counter stores (cycles held - 1) so MAX_HOLD = 2^CNT_W still fits.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]       others_s;
    logic [2:0]       pick_s;

    function automatic logic [2:0] pick_next(input logic [3:0] r, input logic [1:0] from);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = from + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, grant and hold-counter logic.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        last_d   = last_q;
        hold_d   = hold_q;
        others_s = req & ~gnt_q;
        pick_s   = pick_next(others_s, last_q);
        case (state_q)
            IDLE: begin
                if (pick_s[2]) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick_s[1:0];
                    sel_d   = pick_s[1:0];
                    last_d  = pick_s[1:0];
                    hold_d  = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // last_q is the current owner while granted.
                if (!req[last_q] || (hold_q == HOLD_LAST && pick_s[2])) begin
                    if (pick_s[2]) begin
                        gnt_d  = 4'b0001 << pick_s[1:0];
                        sel_d  = pick_s[1:0];
                        last_d = pick_s[1:0];
                        hold_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
            hold_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt  = gnt_q;
    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Randomized and directed bench for mux4_rr_sched, with MAX_HOLD=4 and
// MAX_HOLD=1 instances checked against a behavioural tenure model.
module tb_mux4_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt_a, gnt_b;
    logic       s1_a, s0_a, busy_a, s1_b, s0_b, busy_b;

    int errors = 0;
    int checks = 0;

    int maxh[2]    = '{4, 1};
    int m_owner[2];
    int m_hold[2];
    int m_last[2];
    int m_sel[2];

    always #5 clk = ~clk;

    mux4_rr_sched #(.MAX_HOLD(4), .CNT_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a), .s1(s1_a), .s0(s0_a), .busy(busy_a)
    );

    mux4_rr_sched #(.MAX_HOLD(1), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_b), .s1(s1_b), .s0(s0_b), .busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First requester after 'from' in circular order, or -1.
    function automatic int pick(input int r, input int from);
        for (int d = 1; d <= 4; d++) begin
            if (((r >> ((from + d) % 4)) & 1) != 0) return (from + d) % 4;
        end
        return -1;
    endfunction

    task automatic start_tenure(input int u, input int who);
        m_owner[u] = who;
        m_last[u]  = who;
        m_sel[u]   = who;
        m_hold[u]  = 1;
    endtask

    task automatic model_step(input int u);
        int r;
        int others;
        r = int'(req);
        if (!rst_n) begin
            m_owner[u] = -1; m_hold[u] = 0; m_last[u] = 3; m_sel[u] = 0;
        end else if (m_owner[u] < 0) begin
            if (r != 0) start_tenure(u, pick(r, m_last[u]));
        end else begin
            others = r & ~(1 << m_owner[u]);
            if (((r >> m_owner[u]) & 1) == 0) begin
                if (others != 0) start_tenure(u, pick(others, m_owner[u]));
                else m_owner[u] = -1;
            end else if (m_hold[u] >= maxh[u] && others != 0) begin
                start_tenure(u, pick(others, m_owner[u]));
            end else if (m_hold[u] < maxh[u]) begin
                m_hold[u]++;
            end
        end
    endtask

    task automatic compare_all();
        int g[2];
        int sl[2];
        int b[2];
        g[0] = int'(gnt_a); sl[0] = int'({s1_a, s0_a}); b[0] = int'(busy_a);
        g[1] = int'(gnt_b); sl[1] = int'({s1_b, s0_b}); b[1] = int'(busy_b);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("gnt[%0d]", u), g[u], (m_owner[u] < 0) ? 0 : (1 << m_owner[u]));
            chk($sformatf("sel[%0d]", u), sl[u], m_sel[u]);
            chk($sformatf("busy[%0d]", u), b[u], (m_owner[u] < 0) ? 0 : 1);
            chk($sformatf("onehot0[%0d]", u), ($countones(g[u]) <= 1) ? 1 : 0, 1);
        end
    endtask

    // One clock: model follows the edge, then DUTs are compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int cnt[4];
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        tick();
        chk("rst_gnt", int'(gnt_a), 0);
        chk("rst_sel", int'({s1_a, s0_a}), 0);
        chk("rst_busy", int'(busy_b), 0);
        rst_n = 1'b1;
        tick();
        chk("first_gnt_a", int'(gnt_a), 1);
        chk("first_gnt_b", int'(gnt_b), 1);
        chk("first_busy", int'(busy_a), 1);

        // Single requester held for 10 cycles, then dropped.
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("single_gnt", int'(gnt_a), 4);
            chk("single_sel", int'({s1_a, s0_a}), 2);
        end
        req = 4'b0000;
        tick();
        chk("drop_gnt", int'(gnt_a), 0);
        chk("drop_busy", int'(busy_a), 0);
        chk("drop_sel", int'({s1_a, s0_a}), 2);

        // Two requesters, MAX_HOLD=4: four cycles each.
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rot_gnt", int'(gnt_a), ((i / 4) % 2 == 0) ? 1 : 2);
        end

        // Zero-bubble handover from owner 2 to owner 3.
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        chk("hand_own2", int'(gnt_a), 4);
        req = 4'b1001;
        tick();
        chk("hand_gnt_a", int'(gnt_a), 8);
        chk("hand_gnt_b", int'(gnt_b), 8);
        chk("hand_busy", int'(busy_a), 1);

        // All four with MAX_HOLD=1: strict per-cycle rotation.
        req = 4'b1111;
        cnt = '{0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("wrap_gnt_b", int'(gnt_b), 1 << (i % 4));
            for (int k = 0; k < 4; k++) if (gnt_b[k]) cnt[k]++;
        end
        for (int k = 0; k < 4; k++) chk("wrap_share", cnt[k], 2);

        // Reset in the middle of a tenure, then hold counter restarts.
        req = 4'b0000;
        tick();
        req = 4'b0010;
        tick(); tick(); tick();
        chk("mid_own1", int'(gnt_a), 2);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_gnt", int'(gnt_a), 0);
        chk("mid_rst_busy", int'(busy_a), 0);
        rst_n = 1'b1;
        tick();
        chk("mid_regrant", int'(gnt_a), 2);
        req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_keep", int'(gnt_a), 2);
        end
        tick();
        chk("mid_forced", int'(gnt_a), 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
